// File: rtl/spi_pkg.sv
// Shared definitions for the SPI chip-select controller: FSM state encoding
// and a width helper used for address and guard-counter sizing.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    GUARD    = 2'd2
  } state_t;

  // Bits needed to index n items, never less than one so vectors stay legal.
  function automatic int addr_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_slave_select_if.sv
// Request/status bundle between the SPI master control logic, the slaves'
// MISO lines and the chip-select controller.
interface spi_slave_select_if #(
  parameter int SLAVE_COUNT = 8,
  parameter int AW          = spi_pkg::addr_width(SLAVE_COUNT)
);

  logic                   sel_req;
  logic [AW-1:0]          sel_addr;
  logic                   desel_req;
  logic [SLAVE_COUNT-1:0] CS;
  logic [SLAVE_COUNT-1:0] MISO_in;
  logic                   MISO_out;
  logic                   ready;
  logic                   selected;
  logic [AW-1:0]          cur_addr;
  logic                   req_err;

  modport master (
    output sel_req, sel_addr, desel_req, MISO_in,
    input  CS, MISO_out, ready, selected, cur_addr, req_err
  );

  modport slave (
    input  sel_req, sel_addr, desel_req, MISO_in,
    output CS, MISO_out, ready, selected, cur_addr, req_err
  );

endinterface

// File: rtl/spi_miso_mux.sv
// Routes the selected slave's MISO to a single output, forced to 0 when no
// slave is selected, optionally through one output register.
module spi_miso_mux
  import spi_pkg::*;
#(
  parameter int SLAVE_COUNT = 8,
  parameter int MISO_REG    = 0,
  parameter int AW          = addr_width(SLAVE_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SLAVE_COUNT-1:0] miso_in,
  input  logic                   selected,
  input  logic [AW-1:0]          addr,
  output logic                   miso_out
);

  logic routed;
  logic miso_q;

  assign routed = selected ? miso_in[addr] : 1'b0;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) miso_q <= 1'b0;
    else     miso_q <= routed;
  end

  assign miso_out = (MISO_REG != 0) ? miso_q : routed;

endmodule

// File: rtl/spi_slave_select.sv
// Chip-select controller: one active-low CS at a time, a deselect guard
// interval before the next select, and MISO routing via spi_miso_mux.
module spi_slave_select
  import spi_pkg::*;
#(
  parameter int SLAVE_COUNT  = 8,
  parameter int GUARD_CYCLES = 2,
  parameter int MISO_REG     = 0
) (
  input logic               clk,
  input logic               rst,
  spi_slave_select_if.slave bus
);

  localparam int AW = addr_width(SLAVE_COUNT);
  localparam int GW = addr_width(GUARD_CYCLES + 1);
  localparam logic [AW:0]   SLAVE_LIMIT = (AW + 1)'(SLAVE_COUNT);
  localparam logic [GW-1:0] GUARD_LOAD  = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  state_t                 state, state_n;
  logic [GW-1:0]          cnt, cnt_n;
  logic [SLAVE_COUNT-1:0] cs_q, cs_n;
  logic                   sel_q, sel_n;
  logic [AW-1:0]          addr_q, addr_n;
  logic                   err_q, err_n;
  logic                   in_range;

  function automatic logic [SLAVE_COUNT-1:0] decode(input logic [AW-1:0] a);
    logic [SLAVE_COUNT-1:0] v;
    for (int i = 0; i < SLAVE_COUNT; i++) v[i] = (AW'(i) != a);
    return v;
  endfunction

  // Zero-extended compare; constant-true when SLAVE_COUNT is a power of two.
  assign in_range = ({1'b0, bus.sel_addr} < SLAVE_LIMIT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_n = state;
    cnt_n   = cnt;
    cs_n    = cs_q;
    sel_n   = sel_q;
    addr_n  = addr_q;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.sel_req) begin
          if (in_range) begin
            state_n = SELECTED;
            cs_n    = decode(bus.sel_addr);
            sel_n   = 1'b1;
            addr_n  = bus.sel_addr;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SELECTED: begin
        if (bus.desel_req) begin
          cs_n  = '1;
          sel_n = 1'b0;
          err_n = bus.sel_req;
          if (GUARD_CYCLES > 0) begin
            state_n = GUARD;
            cnt_n   = GUARD_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else if (bus.sel_req) begin
          err_n = 1'b1;
        end
      end
      GUARD: begin
        err_n = bus.sel_req;
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - GW'(1);
      end
      default: begin
        state_n = IDLE;
        cs_n    = '1;
        sel_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      cs_q   <= '1;
      sel_q  <= 1'b0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cs_q   <= cs_n;
      sel_q  <= sel_n;
      addr_q <= addr_n;
      err_q  <= err_n;
    end
  end

  assign bus.CS       = cs_q;
  assign bus.selected = sel_q;
  assign bus.cur_addr = addr_q;
  assign bus.req_err  = err_q;
  assign bus.ready    = (state == IDLE);

  spi_miso_mux #(
    .SLAVE_COUNT (SLAVE_COUNT),
    .MISO_REG    (MISO_REG)
  ) u_miso_mux (
    .clk      (clk),
    .rst      (rst),
    .miso_in  (bus.MISO_in),
    .selected (sel_q),
    .addr     (addr_q),
    .miso_out (bus.MISO_out)
  );

  a_one_cs_low: assert property (@(posedge clk) disable iff (rst) $countones(~cs_q) <= 1);

endmodule

// File: tb/tb_spi_slave_select.sv
// Drives two controller configurations (8 slaves/guard 2/comb MISO and
// 6 slaves/guard 0/registered MISO) with shared stimulus against a reference model.
module tb_spi_slave_select;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_select_if #(.SLAVE_COUNT(8)) bus_a ();
  spi_slave_select_if #(.SLAVE_COUNT(6)) bus_b ();

  spi_slave_select #(.SLAVE_COUNT(8), .GUARD_CYCLES(2), .MISO_REG(0)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  spi_slave_select #(.SLAVE_COUNT(6), .GUARD_CYCLES(0), .MISO_REG(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  int compared   = 0;
  int mismatched = 0;

  // Per-configuration parameters and model state: which slave (if any) is
  // selected, and the first cycle number at which a new select is accepted.
  int    sc [2] = '{8, 6};
  int    gc [2] = '{2, 0};
  int    mr [2] = '{0, 1};
  string nm [2] = '{"a", "b"};
  bit    mv [2];
  int    midx [2];
  int    mready_at [2];
  bit    merr [2];
  bit    mq [2];
  int    cyc;
  logic [7:0] mi_cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; midx[d] = 0; mready_at[d] = 0; merr[d] = 1'b0; mq[d] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic model_edge(input bit sr, input int sa, input bit dr, input logic [7:0] mi);
    for (int d = 0; d < 2; d++) begin
      bit idle;
      mq[d]   = mv[d] ? mi[midx[d]] : 1'b0;
      idle    = !mv[d] && (cyc >= mready_at[d]);
      merr[d] = 1'b0;
      if (mv[d] && dr) begin
        mv[d]        = 1'b0;
        mready_at[d] = cyc + 1 + gc[d];
        merr[d]      = sr;
      end else if (mv[d] && sr) begin
        merr[d] = 1'b1;
      end else if (sr && idle) begin
        if (sa < sc[d]) begin
          mv[d]   = 1'b1;
          midx[d] = sa;
        end else begin
          merr[d] = 1'b1;
        end
      end else if (sr) begin
        merr[d] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] exp_cs, obs_cs, obs_sel, obs_cur, obs_rdy, obs_err, obs_miso;
      bit exp_miso;
      exp_cs = (32'd1 << sc[d]) - 32'd1;
      if (mv[d]) exp_cs = exp_cs & ~(32'd1 << midx[d]);
      if (mr[d] != 0) exp_miso = mq[d];
      else            exp_miso = mv[d] ? mi_cur[midx[d]] : 1'b0;
      if (d == 0) begin
        obs_cs = 32'(bus_a.CS); obs_sel = 32'(bus_a.selected); obs_cur = 32'(bus_a.cur_addr);
        obs_rdy = 32'(bus_a.ready); obs_err = 32'(bus_a.req_err); obs_miso = 32'(bus_a.MISO_out);
      end else begin
        obs_cs = 32'(bus_b.CS); obs_sel = 32'(bus_b.selected); obs_cur = 32'(bus_b.cur_addr);
        obs_rdy = 32'(bus_b.ready); obs_err = 32'(bus_b.req_err); obs_miso = 32'(bus_b.MISO_out);
      end
      check($sformatf("%s.cs", nm[d]),       obs_cs,   exp_cs);
      check($sformatf("%s.selected", nm[d]), obs_sel,  32'(mv[d]));
      check($sformatf("%s.cur_addr", nm[d]), obs_cur,  32'(midx[d]));
      check($sformatf("%s.ready", nm[d]),    obs_rdy,  32'(!mv[d] && (cyc >= mready_at[d])));
      check($sformatf("%s.req_err", nm[d]),  obs_err,  32'(merr[d]));
      check($sformatf("%s.miso_out", nm[d]), obs_miso, 32'(exp_miso));
    end
  endtask

  task automatic step(input bit sr, input int sa, input bit dr, input logic [7:0] mi);
    bus_a.sel_req = sr; bus_a.sel_addr = 3'(sa); bus_a.desel_req = dr; bus_a.MISO_in = mi;
    bus_b.sel_req = sr; bus_b.sel_addr = 3'(sa); bus_b.desel_req = dr; bus_b.MISO_in = mi[5:0];
    mi_cur = mi;
    @(posedge clk);
    model_edge(sr, sa, dr, mi);
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.sel_req = 1'b0; bus_a.sel_addr = '0; bus_a.desel_req = 1'b0; bus_a.MISO_in = '0;
    bus_b.sel_req = 1'b0; bus_b.sel_addr = '0; bus_b.desel_req = 1'b0; bus_b.MISO_in = '0;
    mi_cur = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Select slave 3, then exercise routing on its MISO bit.
    step(1'b1, 3, 1'b0, 8'b0000_0000);
    step(1'b0, 0, 1'b0, 8'b0000_1000);
    step(1'b0, 0, 1'b0, 8'b0000_0000);
    step(1'b0, 0, 1'b0, 8'b1111_0111);
    step(1'b0, 0, 1'b0, 8'b0000_1000);

    // Select while selected, then deselect and probe the guard window.
    step(1'b1, 1, 1'b0, 8'h00);
    step(1'b0, 0, 1'b1, 8'hFF);
    step(1'b1, 2, 1'b0, 8'hFF);
    step(1'b1, 2, 1'b0, 8'hFF);
    step(1'b0, 0, 1'b0, 8'hFF);

    // Address 7: legal for 8 slaves, out of range for 6.
    step(1'b0, 0, 1'b1, 8'h00);
    repeat (3) step(1'b0, 0, 1'b0, 8'h00);
    step(1'b1, 7, 1'b0, 8'h80);
    step(1'b1, 7, 1'b0, 8'h80);
    step(1'b1, 4, 1'b1, 8'h80);
    step(1'b1, 4, 1'b0, 8'h10);
    step(1'b1, 6, 1'b1, 8'h10);
    step(1'b0, 0, 1'b1, 8'h10);

    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3) == 0,
           8'($urandom));
    end

    // Settle both on slave 5 and assert reset between clock edges.
    step(1'b0, 0, 1'b1, 8'h00);
    repeat (3) step(1'b0, 0, 1'b0, 8'h00);
    step(1'b1, 5, 1'b0, 8'hFF);
    step(1'b0, 0, 1'b0, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    check("async.a.cs",       32'(bus_a.CS),       32'h0000_00FF);
    check("async.a.selected", 32'(bus_a.selected), 32'd0);
    check("async.a.miso_out", 32'(bus_a.MISO_out), 32'd0);
    check("async.a.ready",    32'(bus_a.ready),    32'd1);
    check("async.b.cs",       32'(bus_b.CS),       32'h0000_003F);
    check("async.b.selected", 32'(bus_b.selected), 32'd0);
    check("async.b.miso_out", 32'(bus_b.MISO_out), 32'd0);
    check("async.b.cur_addr", 32'(bus_b.cur_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b0, 0, 1'b0, 8'hFF);
    step(1'b1, 2, 1'b0, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_slave_select.md
Name: spi_slave_select

Overview:
- Parametrised chip-select controller and MISO router for the Simple SPI master side. Use it where tri-state MISO is unavailable.
- Accepts select/deselect requests from the master control logic and drives one active-low CS line at a time.
- Enforces a programmable deselect guard time before the next select.
- Routes the selected slave's MISO to a single output, either combinationally or through a register.

Parameters:
- SLAVE_COUNT, 8: number of slaves and CS lines; legal range 2..256.
- GUARD_CYCLES, 2: minimum clk cycles with all CS high between a deselect and the next select; 0 is legal.
- MISO_REG, 0: 0 = MISO_out is combinational from the latched address; 1 = MISO_out is registered, adding one clk cycle of latency.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sel_req  in  1  single-cycle select request
- sel_addr  in  AW = $clog2(SLAVE_COUNT)  slave index, sampled when sel_req=1
- desel_req  in  1  single-cycle deselect request
- CS  out  SLAVE_COUNT  chip selects, active-low
- MISO_in  in  SLAVE_COUNT  per-slave MISO
- MISO_out  out  1  routed MISO
- ready  out  1  high when a select is accepted this cycle (state IDLE)
- selected  out  1  high while a slave is selected
- cur_addr  out  AW  latched index of the selected slave
- req_err  out  1  single-cycle pulse on a rejected request

Behaviour:
- Reset (asynchronous, rst=1) sets:
  - CS to all ones, MISO_out=0, selected=0, cur_addr=0, req_err=0, ready=1;
  - state IDLE, guard counter 0.
- States: IDLE, SELECTED, GUARD.
- IDLE:
  - sel_req=1 with sel_addr<SLAVE_COUNT: next cycle CS[sel_addr]=0, all other CS=1, cur_addr=sel_addr, selected=1, state SELECTED. One cycle of latency from request to CS.
  - sel_req=1 with sel_addr>=SLAVE_COUNT: req_err pulses one cycle later, state stays IDLE, CS unchanged.
  - desel_req alone is ignored silently.
- SELECTED:
  - desel_req=1: next cycle CS all ones, selected=0.
    - If GUARD_CYCLES>0: state GUARD, counter loaded with GUARD_CYCLES-1.
    - If GUARD_CYCLES=0: state IDLE directly.
  - sel_req=1 without desel_req: ignored, req_err pulses, selection unchanged.
  - sel_req and desel_req together: deselect wins, sel_req is rejected with req_err.
- GUARD:
  - CS all high, ready=0.
  - Counter decrements each cycle; at 0 the state becomes IDLE on the next edge.
  - CS stays high for exactly GUARD_CYCLES cycles after the deselect takes effect.
  - sel_req here: req_err pulse, request dropped (not queued). desel_req is ignored.
- ready = (state==IDLE), combinational from state.
- At most one CS bit is low in any cycle; this holds by construction and is checked by an assertion.
- MISO routing:
  - When selected=1, the routed value is MISO_in[cur_addr]; when selected=0 it is 0.
  - MISO_REG=0: MISO_out follows MISO_in[cur_addr] combinationally.
  - MISO_REG=1: MISO_out is that value delayed one clk; after deselect, one stale cycle of the final selected value may appear, then 0.
- Width rules:
  - When SLAVE_COUNT is a power of two, the address range check is trivially true. No truncation is allowed.
  - The guard counter width is $clog2(GUARD_CYCLES+1), minimum 1.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronously), regardless of state.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding (IDLE=2'd0, SELECTED=2'd1, GUARD=2'd2);
  - a helper function for address width (clog2 with a minimum of 1).
- One natural sub-module, spi_miso_mux: parametrised SLAVE_COUNT, indexed mux gated by selected, with optional output register (MISO_REG). The FSM, guard counter and CS decoder stay in the top module.

Test Plan:
- Reset then select: rst pulse; sel_req=1, sel_addr=3 -> next cycle CS=8'b1111_0111, selected=1, cur_addr=3, ready=0, no req_err.
- Routing: while selected on 3, toggle MISO_in=8'b0000_1000 then 8'b0000_0000 -> MISO_out 1 then 0, with 0/1 cycle delay for MISO_REG=0/1. MISO_in=8'b1111_0111 -> MISO_out=0.
- Guard time (GUARD_CYCLES=2): desel_req at cycle t -> CS=8'hFF from t+1; sel_req at t+2 gives req_err at t+3 and is dropped; ready=1 at t+3; sel_req at t+3 drives CS low at t+4.
- Errors: SLAVE_COUNT=6, sel_req with sel_addr=7 in IDLE -> req_err pulse, CS=6'h3F. sel_req in SELECTED -> req_err, cur_addr unchanged. Simultaneous sel_req+desel_req in SELECTED -> deselect plus req_err.
- GUARD_CYCLES=0: desel_req at t -> IDLE at t+1; sel_req at t+1 -> CS low at t+2.
- Async reset mid-select: assert rst between clock edges while CS[5]=0 -> CS=all ones, MISO_out=0, selected=0 immediately, before the next clk edge.
